// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg
//   Shared definitions for the I/D-cache refill arbiter and the caches that
//   talk to it: FSM state encoding, port identifiers, burst geometry defaults
//   and the block-base helper.
package dram_arbiter_pkg;

  // Refill geometry defaults (also used by the caches when sizing lines).
  localparam int unsigned BLOCK_SIZE_DEFAULT   = 8;  // 32-bit beats per refill
  localparam int unsigned ACCESS_DELAY_DEFAULT = 4;  // idle cycles grant -> first read
  localparam int unsigned WORD_W               = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    HOLD
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Block base: word address with the in-block offset bits [2:0] cleared.
  function automatic logic [WORD_W-1:0] block_base(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Arbitrates I-cache and D-cache refill requests onto a single main-memory
//   read port. One port is granted at a time (round-robin on ties); the
//   granted block is read as BLOCK_SIZE consecutive words after ACCESS_DELAY
//   idle cycles, and each word is returned to the granted port one cycle after
//   its read strobe.
//
// Parameters
//   BLOCK_SIZE    beats per refill burst
//   ACCESS_DELAY  idle cycles between grant and first memory read (0 legal)
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   i_req        I-cache refill request (level, held until burst consumed)
//   i_req_addr   I-cache block word address
//   i_data       I-cache refill beat data (0 when not valid)
//   i_val        qualifies i_data for one beat
//   d_req, d_req_addr, d_data, d_val   same for the D-cache
//   mem_rd_en    main-memory word read strobe
//   mem_addr     main-memory word address (0 when not reading)
//   mem_rdata    memory read data, valid the cycle after mem_rd_en
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE   = BLOCK_SIZE_DEFAULT,
  parameter int unsigned ACCESS_DELAY = ACCESS_DELAY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_req_addr,
  output logic [WORD_W-1:0] i_data,
  output logic              i_val,
  input  logic              d_req,
  input  logic [WORD_W-1:0] d_req_addr,
  output logic [WORD_W-1:0] d_data,
  output logic              d_val,
  output logic              mem_rd_en,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata
);

  // Beat counter has one spare bit so it can hold BLOCK_SIZE in HOLD
  // without wrapping back to zero.
  localparam int unsigned CNT_W  = $clog2(BLOCK_SIZE) + 1;
  localparam int unsigned WAIT_W = (ACCESS_DELAY > 1) ? $clog2(ACCESS_DELAY) : 1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((ACCESS_DELAY == 0) ? 0 : ACCESS_DELAY - 1);

  arb_state_t        state_q, state_d;
  port_t             gnt_q, gnt_d;      // current grant; doubles as last-granted
  logic              grant;
  logic              gnt_req;
  logic [WORD_W-1:0] base_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              val_q;             // read strobe delayed to match mem_rdata

  assign gnt_req = (gnt_q == PORT_I) ? i_req : d_req;

  // Next-state and grant selection.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant = 1'b1;
          if (i_req && d_req) begin
            gnt_d = (gnt_q == PORT_D) ? PORT_I : PORT_D;
          end else begin
            gnt_d = i_req ? PORT_I : PORT_D;
          end
          state_d = (ACCESS_DELAY == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat_cnt == LAST_BEAT) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The final beat is presented during the first HOLD cycle, so it has
        // been delivered by any edge taken out of HOLD; only the requester's
        // level gates the exit, which stops a still-high req re-triggering.
        if (!gnt_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= PORT_D;
      base_q   <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      val_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      val_q   <= mem_rd_en;

      if (grant) begin
        base_q <= block_base((gnt_d == PORT_I) ? i_req_addr : d_req_addr);
      end

      if (state_q == WAIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (state_q == BURST) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end else if (state_q == IDLE) begin
        beat_cnt <= '0;
      end
    end
  end

  assign mem_rd_en = (state_q == BURST);
  assign mem_addr  = mem_rd_en ? (base_q + WORD_W'(beat_cnt)) : '0;

  // gnt_q cannot change before the last beat is returned (next grant needs
  // an IDLE cycle after HOLD), so it still names the owner of the beat.
  assign i_val  = val_q && (gnt_q == PORT_I);
  assign d_val  = val_q && (gnt_q == PORT_D);
  assign i_data = i_val ? mem_rdata : '0;
  assign d_data = d_val ? mem_rdata : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
`timescale 1ns/1ps
// Testbench for dram_arbiter: two instances (default geometry, and
// ACCESS_DELAY=0 with a 4-beat block) checked against a transaction-level
// reference model through expected-issue and expected-beat queues.
module tb_dram_arbiter;

  localparam int NU  = 2;
  localparam int BS0 = 8;
  localparam int AD0 = 4;
  localparam int BS1 = 4;
  localparam int AD1 = 0;
  localparam int LIMIT = 200;

  function automatic int bs_of(input int u);
    return (u == 0) ? BS0 : BS1;
  endfunction

  function automatic int ad_of(input int u);
    return (u == 0) ? AD0 : AD1;
  endfunction

  // Memory content as a pure function of word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req   [NU][2];
  logic [31:0] addr  [NU][2];
  logic [31:0] data  [NU][2];
  logic        val   [NU][2];
  logic        rd_en [NU];
  logic [31:0] maddr [NU];
  logic [31:0] rdata [NU];

  always #5 clk = ~clk;

  dram_arbiter #(.BLOCK_SIZE(BS0), .ACCESS_DELAY(AD0)) dut (
    .clk(clk), .reset(reset),
    .i_req(req[0][0]), .i_req_addr(addr[0][0]), .i_data(data[0][0]), .i_val(val[0][0]),
    .d_req(req[0][1]), .d_req_addr(addr[0][1]), .d_data(data[0][1]), .d_val(val[0][1]),
    .mem_rd_en(rd_en[0]), .mem_addr(maddr[0]), .mem_rdata(rdata[0])
  );

  dram_arbiter #(.BLOCK_SIZE(BS1), .ACCESS_DELAY(AD1)) dut_z (
    .clk(clk), .reset(reset),
    .i_req(req[1][0]), .i_req_addr(addr[1][0]), .i_data(data[1][0]), .i_val(val[1][0]),
    .d_req(req[1][1]), .d_req_addr(addr[1][1]), .d_data(data[1][1]), .d_val(val[1][1]),
    .mem_rd_en(rd_en[1]), .mem_addr(maddr[1]), .mem_rdata(rdata[1])
  );

  // Main memory: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rd_en[u]) rdata[u] <= memfn(maddr[u]);
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int e; logic [31:0] a; } iss_t;
  typedef struct { int e; int p; logic [31:0] d; } beat_t;

  iss_t  q_iss  [NU][$];
  beat_t q_beat [NU][$];

  int n = 0;               // rising-edge count
  bit busy   [NU];
  int gport  [NU];
  int rel_e  [NU];         // earliest edge at which the owner may release
  bit last_d [NU];
  bit gflag  [NU][2];      // set when the model grants a port

  int n_vec = 0;
  int n_err = 0;

  // A grant at edge g reads words base+k after edges g+AD+k and returns
  // them after edges g+AD+1+k; the port keeps the memory until it has been
  // seen low at or after edge g+AD+BS+1, and the next grant needs one more edge.
  function automatic void model_step(input int u);
    int p;
    logic [31:0] base;
    iss_t it;
    beat_t bt;
    if (busy[u]) begin
      if (n >= rel_e[u] && !req[u][gport[u]]) busy[u] = 1'b0;
    end else if (req[u][0] || req[u][1]) begin
      if (req[u][0] && req[u][1]) p = last_d[u] ? 0 : 1;
      else                        p = req[u][1] ? 1 : 0;
      base = addr[u][p] & ~32'h7;
      for (int k = 0; k < bs_of(u); k++) begin
        it.e = n + ad_of(u) + k;
        it.a = base + 32'(k);
        q_iss[u].push_back(it);
        bt.e = n + ad_of(u) + 1 + k;
        bt.p = p;
        bt.d = memfn(base + 32'(k));
        q_beat[u].push_back(bt);
      end
      busy[u]     = 1'b1;
      gport[u]    = p;
      last_d[u]   = (p == 1);
      rel_e[u]    = n + ad_of(u) + bs_of(u) + 1;
      gflag[u][p] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    n = n + 1;
    if (reset) begin
      for (int u = 0; u < NU; u++) model_step(u);
    end
  end

  // Reset aborts everything in flight.
  always @(negedge reset) begin
    for (int u = 0; u < NU; u++) begin
      q_iss[u].delete();
      q_beat[u].delete();
      busy[u]     = 1'b0;
      last_d[u]   = 1'b1;
      gflag[u][0] = 1'b0;
      gflag[u][1] = 1'b0;
    end
  end

  function automatic void check(input string nm, input int u,
                                input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d edge %0d: got %h, expected %h", nm, u, n, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (!reset) begin
        check("reset_outputs", u,
              128'({rd_en[u], maddr[u], val[u][0], data[u][0], val[u][1], data[u][1]}), '0);
      end else begin
        while (q_iss[u].size() > 0 && q_iss[u][0].e < n) begin
          check("issue_missed", u, 128'(q_iss[u][0].e), 128'(n));
          void'(q_iss[u].pop_front());
        end
        while (q_beat[u].size() > 0 && q_beat[u][0].e < n) begin
          check("beat_missed", u, 128'(q_beat[u][0].e), 128'(n));
          void'(q_beat[u].pop_front());
        end

        if (q_iss[u].size() > 0 && q_iss[u][0].e == n) begin
          check("mem_issue", u, 128'({rd_en[u], maddr[u]}), 128'({1'b1, q_iss[u][0].a}));
          void'(q_iss[u].pop_front());
        end else begin
          check("mem_idle", u, 128'(rd_en[u]), '0);
        end

        if (q_beat[u].size() > 0 && q_beat[u][0].e == n) begin
          int bp;
          bp = q_beat[u][0].p;
          check("beat", u,
                128'({val[u][0], val[u][1], data[u][bp], data[u][1-bp]}),
                128'({bp == 0, bp == 1, q_beat[u][0].d, 32'h0}));
          void'(q_beat[u].pop_front());
        end else begin
          check("no_beat", u, 128'({val[u][0], val[u][1]}), '0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // All stimulus runs 1 ns after a rising edge.
  task automatic cyc(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input int u, input int p, output bit ok);
    int c = 0;
    while (!gflag[u][p] && c < LIMIT) begin
      @(posedge clk);
      #1;
      c++;
    end
    ok = gflag[u][p];
    gflag[u][p] = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL grant_timeout inst%0d port%0d: got no grant, expected one within %0d cycles",
               u, p, LIMIT);
    end
  endtask

  // Request a block, scramble the address after grant, drop the request
  // 'extra' cycles after the first beat slot (mid-burst or well after).
  task automatic do_req(input int u, input int p, input logic [31:0] a, input int extra);
    bit ok;
    int c;
    addr[u][p] = a;
    req[u][p]  = 1'b1;
    wait_grant(u, p, ok);
    addr[u][p] = $urandom();
    if (ok) cyc(ad_of(u) + 1 + extra);
    req[u][p] = 1'b0;
    c = 0;
    while (busy[u] && gport[u] == p && c < LIMIT) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic rand_proc(input int u, input int p, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      cyc($urandom_range(0, 3));
      do_req(u, p, $urandom(), $urandom_range(0, bs_of(u) + 3));
    end
  endtask

  initial begin
    bit ok;
    for (int u = 0; u < NU; u++) begin
      rdata[u] = '0;
      busy[u] = 1'b0;
      last_d[u] = 1'b1;
      gport[u] = 0;
      rel_e[u] = 0;
      for (int p = 0; p < 2; p++) begin
        req[u][p]   = 1'b0;
        addr[u][p]  = '0;
        gflag[u][p] = 1'b0;
      end
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cyc(2);

    // Single I request, unaligned address, held 3 cycles past the last beat.
    do_req(0, 0, 32'h0000_0104, BS0 + 3);
    cyc(2);

    // Short reset pulse between bursts, then ties straight after reset.
    #1 reset = 1'b0;
    cyc(1);
    #1 reset = 1'b1;
    cyc(1);
    for (int r = 0; r < 3; r++) begin
      fork
        do_req(0, 0, $urandom(), 0);
        do_req(0, 1, $urandom(), 2);
        do_req(1, 0, $urandom(), 1);
        do_req(1, 1, $urandom(), 0);
      join
      cyc(1);
    end

    // D request dropped right after beat 3.
    do_req(0, 1, 32'h0000_2000, 3);
    cyc(2);

    // Random contention on both instances.
    fork
      rand_proc(0, 0, 6);
      rand_proc(0, 1, 6);
      rand_proc(1, 0, 8);
      rand_proc(1, 1, 8);
    join
    cyc(3);

    // Reset during beat 5 of a D burst.
    addr[0][1] = 32'h0000_3008;
    req[0][1]  = 1'b1;
    wait_grant(0, 1, ok);
    if (ok) cyc(AD0 + 5);
    #1 reset = 1'b0;
    #1 check("async_reset", 0,
             128'({rd_en[0], maddr[0], val[0][0], data[0][0], val[0][1], data[0][1]}), '0);
    req[0][1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(8);

    // Recovery: a fresh request after the aborted burst.
    do_req(0, 0, 32'h0000_4010, 1);
    cyc(BS0 + AD0 + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of stimulus, expected it within 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
